// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped 16x4-word instruction cache controller
// Hits return one cycle later; misses refill the whole line in word order.
module icache_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_pc_i,
  input  logic        fc_flush_icache_i,
  input  logic        fc_invalidate_i,
  output logic        Icache_ready_o,
  output logic [31:0] Icache_inst_o,
  output logic        Icache_busy_o,
  output logic        Icache_mem_req_o,
  output logic [31:0] Icache_mem_addr_o,
  input  logic        mem_Icache_ack_i,
  input  logic [31:0] mem_Icache_rdata_i
);

  localparam int LINES = 16;
  localparam int WORDS = 4;

  typedef enum logic {S_IDLE, S_REFILL} state_e;

  state_e            state_q;
  logic [LINES-1:0]  valid_q;
  logic [23:0]       tag_q  [LINES];
  logic [31:0]       data_q [LINES][WORDS];

  logic [23:0]       rtag_q;
  logic [3:0]        ridx_q;
  logic [1:0]        roff_q;
  logic [1:0]        cnt_q;
  logic              drop_q;
  logic              inv_pend_q;
  logic              ready_q;
  logic [31:0]       inst_q;
  logic              mem_req_q;
  logic [31:0]       mem_addr_q;

  logic [23:0]       req_tag;
  logic [3:0]        req_idx;
  logic [1:0]        req_off;
  logic [1:0]        cnt_nxt;
  logic              hit;
  logic              fill_ack;
  logic              unused_pc_lsb;

  assign req_tag       = if_pc_i[31:8];
  assign req_idx       = if_pc_i[7:4];
  assign req_off       = if_pc_i[3:2];
  assign unused_pc_lsb = ^if_pc_i[1:0];
  assign cnt_nxt       = cnt_q + 2'd1;
  assign fill_ack      = (state_q == S_REFILL) && mem_Icache_ack_i;
  assign hit           = (state_q == S_IDLE) && if_req_i && valid_q[req_idx] &&
                         (tag_q[req_idx] == req_tag) && !fc_invalidate_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      rtag_q     <= '0;
      ridx_q     <= '0;
      roff_q     <= '0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      inv_pend_q <= 1'b0;
      ready_q    <= 1'b0;
      inst_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fc_invalidate_i) valid_q <= '0;
          if (if_req_i && !fc_flush_icache_i) begin
            if (hit) begin
              ready_q <= 1'b1;
              inst_q  <= data_q[req_idx][req_off];
            end else begin
              // The line is being overwritten, so it must not look valid meanwhile.
              valid_q[req_idx] <= 1'b0;
              state_q          <= S_REFILL;
              rtag_q           <= req_tag;
              ridx_q           <= req_idx;
              roff_q           <= req_off;
              cnt_q            <= 2'd0;
              mem_req_q        <= 1'b1;
              mem_addr_q       <= {req_tag, req_idx, 4'b0000};
            end
          end
        end
        S_REFILL: begin
          if (fc_flush_icache_i) drop_q <= 1'b1;
          if (fc_invalidate_i)   inv_pend_q <= 1'b1;
          if (mem_Icache_ack_i) begin
            cnt_q <= cnt_nxt;
            if (cnt_q == 2'd3) begin
              state_q    <= S_IDLE;
              mem_req_q  <= 1'b0;
              drop_q     <= 1'b0;
              inv_pend_q <= 1'b0;
              if (inv_pend_q || fc_invalidate_i) valid_q <= '0;
              else valid_q[ridx_q] <= 1'b1;
              if (!(drop_q || fc_flush_icache_i)) begin
                ready_q <= 1'b1;
                // Word 3 is still in flight to the array this cycle.
                inst_q  <= (roff_q == 2'd3) ? mem_Icache_rdata_i : data_q[ridx_q][roff_q];
              end
            end else begin
              mem_addr_q <= {rtag_q, ridx_q, cnt_nxt, 2'b00};
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_ack) begin
      data_q[ridx_q][cnt_q] <= mem_Icache_rdata_i;
      if (cnt_q == 2'd3) tag_q[ridx_q] <= rtag_q;
    end
  end

  assign Icache_ready_o    = ready_q;
  assign Icache_inst_o     = inst_q;
  assign Icache_busy_o     = (state_q == S_REFILL);
  assign Icache_mem_req_o  = mem_req_q;
  assign Icache_mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - scoreboard bench for icache_ctrl
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] pc;
  logic        flush;
  logic        inv;
  logic        ack;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] inst;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          rdy_cnt  = 0;
  int          budget   = 1000000;
  int          r0;
  logic [31:0] sb[$];
  logic [31:0] addr_q[$];

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .if_req_i           (if_req),
    .if_pc_i            (pc),
    .fc_flush_icache_i  (flush),
    .fc_invalidate_i    (inv),
    .Icache_ready_o     (ready),
    .Icache_inst_o      (inst),
    .Icache_busy_o      (busy),
    .Icache_mem_req_o   (mem_req),
    .Icache_mem_addr_o  (mem_addr),
    .mem_Icache_ack_i   (ack),
    .mem_Icache_rdata_i (rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a[31:4] == 28'h0000010) return 32'hA0 + {30'h0, a[3:2]};
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a);
    if_req = 1'b1;
    pc     = a;
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check_eq("refill_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_budget();
    for (int i = 0; i < 100 && budget > 0; i++) @(negedge clk);
    check_eq("ack_budget_timeout", budget, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    ack   = 1'b0;
    rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && rst_n && budget > 0) begin
        ack   = 1'b1;
        rdata = mem_data(mem_addr);
        addr_q.push_back(mem_addr);
        budget--;
      end else begin
        ack = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ready === 1'b1) begin
        rdy_cnt++;
        if (sb.size() == 0) check_eq("unexpected_ready", 32'd1, 32'd0);
        else check_eq("inst", inst, sb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b0; pc = '0; flush = 1'b0; inv = 1'b0;
    tick(2);
    check_eq("rst_ready", {31'b0, ready}, 32'd0);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    tick(1);

    addr_q.delete();
    sb.push_back(32'hA1);
    issue(32'h0000_0104);
    check_eq("cold_busy", {31'b0, busy}, 32'd1);
    wait_idle();
    tick(1);
    check_eq("cold_naddr", addr_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      check_eq("cold_addr", addr_q[i], 32'h100 + 32'(4 * i));

    r0 = rdy_cnt;
    sb.push_back(32'hA0); sb.push_back(32'hA2); sb.push_back(32'hA3);
    if_req = 1'b1;
    pc = 32'h100; tick(1);
    pc = 32'h108; tick(1);
    pc = 32'h10C; tick(1);
    if_req = 1'b0;
    check_eq("hit_no_busy", {31'b0, busy}, 32'd0);
    tick(1);
    check_eq("hit_stream_readies", rdy_cnt - r0, 32'd3);

    addr_q.delete();
    sb.push_back(mem_data(32'h200));
    issue(32'h0000_0200);
    check_eq("conflict_busy", {31'b0, busy}, 32'd1);
    wait_idle();
    tick(1);
    check_eq("conflict_naddr", addr_q.size(), 32'd4);
    if (addr_q.size() == 4) begin
      check_eq("conflict_addr0", addr_q[0], 32'h200);
      check_eq("conflict_addr3", addr_q[3], 32'h20C);
    end
    sb.push_back(32'hA1);
    issue(32'h0000_0104);
    check_eq("conflict_remiss", {31'b0, busy}, 32'd1);
    wait_idle();
    tick(1);

    r0 = rdy_cnt;
    budget = 2;
    issue(32'h0000_0300);
    wait_budget();
    check_eq("flush_in_refill", {31'b0, busy}, 32'd1);
    flush = 1'b1; tick(1); flush = 1'b0;
    budget = 1000000;
    wait_idle();
    tick(2);
    check_eq("flush_drop", rdy_cnt - r0, 32'd0);
    sb.push_back(mem_data(32'h304));
    issue(32'h0000_0304);
    check_eq("flush_line_hit", {31'b0, busy}, 32'd0);
    tick(1);

    r0 = rdy_cnt;
    flush = 1'b1; if_req = 1'b1; pc = 32'h300;
    tick(1);
    flush = 1'b0; if_req = 1'b0;
    tick(1);
    check_eq("idle_flush_no_ready", rdy_cnt - r0, 32'd0);
    check_eq("idle_flush_no_busy", {31'b0, busy}, 32'd0);

    inv = 1'b1; tick(1); inv = 1'b0;
    addr_q.delete();
    sb.push_back(32'hA0);
    issue(32'h0000_0100);
    check_eq("inv_miss", {31'b0, busy}, 32'd1);
    wait_idle();
    tick(1);
    check_eq("inv_naddr", addr_q.size(), 32'd4);

    budget = 2;
    issue(32'h0000_0404);
    wait_budget();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ready", {31'b0, ready}, 32'd0);
    check_eq("midrst_inst", inst, 32'd0);
    check_eq("midrst_busy", {31'b0, busy}, 32'd0);
    check_eq("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    check_eq("midrst_mem_addr", mem_addr, 32'd0);
    tick(1);
    rst_n = 1'b1;
    budget = 1000000;
    sb.push_back(mem_data(32'h404));
    issue(32'h0000_0404);
    check_eq("post_reset_miss", {31'b0, busy}, 32'd1);
    wait_idle();
    tick(3);
    check_eq("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameters SHALL be fixed, with no overrides: LINES = 16 (number of cache lines); WORDS = 4 (32-bit words per line).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 if_req_i  input  1  fetch request from IF, qualified by if_pc_i.
REQ-005 if_pc_i  input  32  fetch address; bits [1:0] SHALL be ignored.
REQ-006 fc_flush_icache_i  input  1  flow-control flush; drops any pending response.
REQ-007 fc_invalidate_i  input  1  fence.i pulse; invalidates all lines.
REQ-008 Icache_ready_o  output  1  one-cycle strobe; Icache_inst_o is valid this cycle.
REQ-009 Icache_inst_o  output  32  returned instruction word.
REQ-010 Icache_busy_o  output  1  high while a refill is in progress; IF SHALL hold its PC.
REQ-011 Icache_mem_req_o  output  1  memory read request, level-held until acked.
REQ-012 Icache_mem_addr_o  output  32  word-aligned memory read address.
REQ-013 mem_Icache_ack_i  input  1  memory returns one word this cycle.
REQ-014 mem_Icache_rdata_i  input  32  memory read data, valid with the ack.

Function
REQ-015 The cache SHALL be direct-mapped; address fields: offset = pc[3:2], index = pc[7:4], tag = pc[31:8].
REQ-016 Storage per line SHALL be: one valid bit, a 24-bit tag, and 4x32-bit data words.
REQ-017 The controller SHALL have two states: IDLE and REFILL.
REQ-018 Hit definition: in IDLE, if_req_i=1, valid[index]=1, tag matches, and fc_invalidate_i=0.
REQ-019 On a hit, the next cycle SHALL show Icache_ready_o=1 and Icache_inst_o=data[index][offset].
REQ-020 Hits SHALL be fully pipelined: back-to-back hits give one ready per cycle.
REQ-021 On a miss in IDLE, the controller SHALL latch the pc, go to REFILL, and clear the word counter to 0.
REQ-022 Icache_busy_o SHALL equal (state==REFILL).
REQ-023 In REFILL, Icache_mem_req_o SHALL be 1 and Icache_mem_addr_o = {tag, index, cnt, 2'b00}; words are fetched 0..3 in order, with no critical-word-first.
REQ-024 Each mem_Icache_ack_i in REFILL SHALL write rdata into data[index][cnt], then cnt+1.
REQ-025 On the ack with cnt==3, the controller SHALL set valid[index], write the tag, and return to IDLE.
REQ-026 In the cycle after that final ack, it SHALL drive Icache_ready_o=1 with the latched-offset word, unless the drop flag is set.
REQ-027 The cycle after the final ack SHALL be IDLE; a new request SHALL be accepted in that cycle.
REQ-028 if_req_i in REFILL SHALL be ignored; mem_Icache_ack_i in IDLE SHALL be ignored.
REQ-029 Flush SHALL not retract a ready already high in the current cycle.
REQ-030 Flush in IDLE: no ready SHALL be produced next cycle, and a request in the same cycle SHALL be ignored.
REQ-031 Flush in REFILL SHALL set the drop flag; the refill completes and installs the line but produces no ready; the drop flag clears on return to IDLE.
REQ-032 Invalidate in IDLE SHALL clear all valid bits next cycle; a request in the same cycle is treated as a miss.
REQ-033 Invalidate in REFILL SHALL be recorded and applied when the refill completes, clearing all valid bits including the new line.
REQ-034 Icache_inst_o SHALL hold its last value when Icache_ready_o=0.
REQ-035 Icache_mem_addr_o SHALL hold its last value outside REFILL.

Reset
REQ-036 On rst_n=0, asynchronously: state=IDLE, all valid=0, cnt=0, drop and pending-invalidate flags=0, Icache_ready_o=0, Icache_inst_o=0, Icache_mem_req_o=0, Icache_mem_addr_o=0.
REQ-037 Tag and data arrays SHALL not require reset.
REQ-038 Reset asserted mid-refill SHALL abandon the refill with no line installed.

Verification
REQ-039 Cold miss: req pc=0x0000_0104, memory acks every cycle with data 0xA0..0xA3 -> addresses 0x100, 0x104, 0x108, 0x10C issued; ready strobe with inst=0xA1 one cycle after the 4th ack.
REQ-040 Hit stream: after the cold miss, req pc=0x100, 0x108, 0x10C on consecutive cycles -> ready on 3 consecutive cycles with 0xA0, 0xA2, 0xA3.
REQ-041 Conflict: req pc=0x0000_0200 (same index 0, different tag) -> refill from 0x200; a later req to 0x104 misses again.
REQ-042 Flush mid-refill: fc_flush_icache_i pulsed after the 2nd ack -> refill completes, no ready produced; the next req to the same line hits.
REQ-043 Invalidate: pulse fc_invalidate_i in IDLE, then req pc=0x100 -> miss, busy=1, full 4-word refill.
REQ-044 Reset during REFILL after 2 acks -> all outputs 0 immediately; a subsequent req to that line misses.
